// File: rtl/if_fetch_pkg.sv
// Shared widths, reset PC, FSM encoding and FIFO entry type for the instruction fetch stage.
package if_fetch_pkg;

    localparam int INST_W     = 32;
    localparam int XLEN       = 64;
    localparam int FIFO_DEPTH = 2;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

endinterface

// File: rtl/if_fetch_fifo.sv
// Two-entry instruction FIFO with flush; pointers wrap modulo 2, simultaneous push/pop keeps count.
module if_fetch_fifo
    import if_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [FIFO_DEPTH];
    fetch_entry_t mem_d [FIFO_DEPTH];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q,  count_d;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; storage is reset too
    // (two entries) so the head reads zero straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'(FIFO_DEPTH));

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: single-outstanding imem requests, redirect handling, 2-entry decode FIFO.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic              clk,
    input  logic              rst,
    if_fetch_if.master        imem,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic         outstanding;
    logic         credit_ok;
    logic         req_valid;
    logic         req_hs;
    logic         rsp_keep;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [1:0]   fifo_count;
    fetch_entry_t fifo_head;

    // Only one request may be in flight, so the credit sum is effectively checked in IDLE;
    // this gives one instruction every two cycles against a one-cycle memory.
    assign outstanding = (state_q != S_IDLE);
    assign credit_ok   = (fifo_count + {1'b0, outstanding}) < 2'd2;
    assign req_valid   = !rst && !redirect_valid && !outstanding && credit_ok;
    assign req_hs      = req_valid && imem.imem_req_ready;
    assign rsp_keep    = (state_q == S_WAIT) && imem.imem_rsp_valid && !redirect_valid;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;

        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
        end else if (req_hs) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
            req_pc_d   = fetch_pc_q;
        end

        unique case (state_q)
            S_IDLE: if (req_hs) state_d = S_WAIT;
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem.imem_rsp_valid ? S_IDLE : S_DROP;
                end else if (imem.imem_rsp_valid) begin
                    state_d = req_hs ? S_WAIT : S_IDLE;
                end
            end
            S_DROP: if (imem.imem_rsp_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    if_fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_keep),
        .push_data ('{inst: imem.imem_rsp_data, pc: req_pc_q}),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign inst_valid = !rst && !fifo_empty && !redirect_valid;
    assign fifo_pop   = inst_valid && inst_ready;
    assign inst       = fifo_head.inst;
    assign inst_pc    = fifo_head.pc;

    // The credit rule makes a push into a full FIFO impossible.
    always @(posedge clk) begin
        if (!rst) assert (!(rsp_keep && fifo_full));
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized traffic vs a stream model.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    always #5 clk = ~clk;

    if_fetch_if imem ();

    if_fetch #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs for the coming cycle
    bit          drv_ready, drv_redirect, drv_inst_ready, drv_stale;
    logic [63:0] drv_rpc;
    int          mem_lat;

    // Memory model: one pending request answered mem_lat cycles after its handshake
    bit          pending;
    logic [63:0] mem_addr;
    int          mem_cnt;

    // Stream model: both request and decode streams are sequential from the last redirect
    logic [63:0] exp_req_pc, exp_inst_pc;
    bit          hold_prev;
    logic [63:0] hold_addr;
    logic [63:0] hs_q[$];
    logic [63:0] pop_q[$];
    int          pop_cyc_q[$];
    int          cyc;

    logic        s_req_valid, s_inst_valid;
    logic [63:0] s_req_addr, s_inst_pc;
    logic [31:0] s_inst;

    function automatic logic [31:0] memf(input logic [63:0] a);
        return {a[7:0], a[31:8]} ^ a[63:32] ^ 32'hC0DE_F00D;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit rsp_now, hs, pop;
        rsp_now = (!rst && pending && mem_cnt == 0) || drv_stale;
        imem.imem_req_ready = drv_ready;
        imem.imem_rsp_valid = rsp_now;
        imem.imem_rsp_data  = drv_stale ? 32'hDEAD_BEEF : memf(mem_addr);
        redirect_valid      = drv_redirect;
        redirect_pc         = drv_rpc;
        inst_ready          = drv_inst_ready;
        #1;
        s_req_valid  = imem.imem_req_valid;
        s_req_addr   = imem.imem_req_addr;
        s_inst_valid = inst_valid;
        s_inst       = inst;
        s_inst_pc    = inst_pc;
        hs  = (s_req_valid === 1'b1) && drv_ready;
        pop = (s_inst_valid === 1'b1) && drv_inst_ready;
        if (rst) begin
            check("rst_req_valid", s_req_valid, 0);
            check("rst_inst_valid", s_inst_valid, 0);
            pending = 0; hold_prev = 0; cyc = 0;
            exp_req_pc = RPC; exp_inst_pc = RPC;
            hs_q.delete(); pop_q.delete(); pop_cyc_q.delete();
        end else begin
            if (hold_prev && !drv_redirect) begin
                check("req_hold_valid", s_req_valid, 1);
                check("req_hold_addr", s_req_addr, hold_addr);
            end
            if (s_req_valid === 1'b1) check("req_addr", s_req_addr, exp_req_pc);
            if (drv_redirect) begin
                check("redir_no_req", s_req_valid, 0);
                check("redir_no_inst", s_inst_valid, 0);
            end
            if (s_inst_valid === 1'b1) begin
                check("inst_pc", s_inst_pc, exp_inst_pc);
                check("inst_data", s_inst, memf(exp_inst_pc));
            end
            if (hs) begin
                check("one_outstanding", pending && !rsp_now, 0);
                hs_q.push_back(s_req_addr);
                exp_req_pc += 64'd4;
            end
            if (pop) begin
                pop_q.push_back(s_inst_pc);
                pop_cyc_q.push_back(cyc);
                exp_inst_pc += 64'd4;
            end
            if (drv_redirect) begin
                exp_req_pc  = {drv_rpc[63:2], 2'b00};
                exp_inst_pc = {drv_rpc[63:2], 2'b00};
            end
            hold_prev = (s_req_valid === 1'b1) && !drv_ready && !drv_redirect;
            hold_addr = s_req_addr;
            if (rsp_now) pending = 0;
            else if (pending) mem_cnt--;
            if (hs) begin
                pending  = 1;
                mem_addr = s_req_addr;
                mem_cnt  = mem_lat - 1;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic post_reset_checks();
        check("post_rst_req_valid", imem.imem_req_valid, 0);
        check("post_rst_inst_valid", inst_valid, 0);
        check("post_rst_inst", inst, 0);
        check("post_rst_inst_pc", inst_pc, 0);
    endtask

    task automatic do_reset();
        drv_ready = 1; drv_redirect = 0; drv_inst_ready = 1; drv_stale = 0;
        drv_rpc = '0; mem_lat = 1;
        rst = 1;
        cycle();
        cycle();
        post_reset_checks();
        rst = 0;
    endtask

    initial begin
        pending = 0; mem_addr = '0; mem_cnt = 0;

        // Reset, then streaming with a one-cycle memory
        do_reset();
        cycle();
        check("first_req_valid", s_req_valid, 1);
        check("first_req_addr", s_req_addr, RPC);
        repeat (11) cycle();
        check("stream_hs0", hs_q[0], RPC);
        check("stream_hs1", hs_q[1], RPC + 64'd4);
        check("stream_hs2", hs_q[2], RPC + 64'd8);
        check("stream_pops", pop_q.size(), 5);
        check("stream_pop0_pc", pop_q[0], RPC);
        check("stream_pop0_cyc", pop_cyc_q[0], 2);
        check("stream_pop1_cyc", pop_cyc_q[1], 4);

        // Decode stalled: FIFO fills to two and requests stop
        do_reset();
        drv_inst_ready = 0;
        repeat (10) cycle();
        check("fill_req_off", s_req_valid, 0);
        check("fill_inst_valid", s_inst_valid, 1);
        check("fill_hs_cnt", hs_q.size(), 2);
        drv_inst_ready = 1;
        cycle();
        check("fill_pop_cnt", pop_q.size(), 1);
        check("fill_first_pop", pop_q[0], RPC);

        // Redirect while WAIT with one FIFO entry: entry flushed, response dropped
        do_reset();
        drv_inst_ready = 0;
        cycle();
        cycle();
        mem_lat = 3;
        cycle();
        drv_redirect = 1; drv_rpc = 64'h0000_0000_8000_1002;
        cycle();
        drv_redirect = 0; drv_inst_ready = 1; mem_lat = 1;
        cycle();
        check("drop_no_req", s_req_valid, 0);
        repeat (8) cycle();
        check("redir_hs_addr", hs_q[2], 64'h0000_0000_8000_1000);
        check("redir_first_pop", pop_q[0], 64'h0000_0000_8000_1000);

        // Redirect in the same cycle as the response
        do_reset();
        mem_lat = 2;
        cycle();
        mem_lat = 1;
        cycle();
        drv_redirect = 1; drv_rpc = 64'h0000_0000_9000_0000;
        cycle();
        drv_redirect = 0;
        cycle();
        check("samecyc_req_valid", s_req_valid, 1);
        check("samecyc_req_addr", s_req_addr, 64'h0000_0000_9000_0000);
        repeat (4) cycle();
        check("samecyc_first_pop", pop_q[0], 64'h0000_0000_9000_0000);

        // Memory not ready: request held, PC does not advance
        do_reset();
        drv_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_valid", s_req_valid, 1);
            check("stall_addr", s_req_addr, RPC);
        end
        check("stall_no_hs", hs_q.size(), 0);
        drv_ready = 1;
        cycle();
        check("stall_hs_addr", hs_q[0], RPC);
        cycle();
        cycle();
        check("stall_next_valid", s_req_valid, 1);
        check("stall_next_addr", s_req_addr, RPC + 64'd4);

        // Reset during WAIT with one FIFO entry; stale response right after reset
        do_reset();
        drv_inst_ready = 0;
        cycle();
        cycle();
        mem_lat = 3;
        cycle();
        rst = 1;
        cycle();
        post_reset_checks();
        rst = 0; drv_stale = 1; drv_inst_ready = 1; mem_lat = 1;
        cycle();
        drv_stale = 0;
        check("restart_req_valid", s_req_valid, 1);
        check("restart_req_addr", s_req_addr, RPC);
        repeat (3) cycle();
        check("restart_first_pop", pop_q[0], RPC);

        // Randomized traffic, including redirects near the top of the address space
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            drv_ready      = ($urandom_range(0, 9) < 7);
            drv_inst_ready = ($urandom_range(0, 9) < 6);
            mem_lat        = $urandom_range(1, 3);
            drv_redirect   = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 3) == 0)
                drv_rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            else
                drv_rpc = {$urandom, $urandom};
            cycle();
        end
        check("rand_progress", pop_q.size() > 200, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, address of the first fetch after reset.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 Port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-006 Port imem_req_addr  output  64  fetch address, bits [1:0] always 0.
REQ-007 Port imem_rsp_valid  input  1  response data valid; always accepted, no backpressure.
REQ-008 Port imem_rsp_data  input  32  fetched instruction word.
REQ-009 Port redirect_valid  input  1  branch/jump redirect from a later stage.
REQ-010 Port redirect_pc  input  64  new fetch target.
REQ-011 Port inst_valid  output  1  instruction available to decode.
REQ-012 Port inst_ready  input  1  decode consumes the instruction this cycle.
REQ-013 Port inst  output  32  instruction word to decode.
REQ-014 Port inst_pc  output  64  PC of inst.

Function
REQ-015 A fetch PC register holds the next request address and resets to RESET_PC.
REQ-016 The block SHALL hold at most one outstanding memory request.
REQ-017 The request SHALL be issued only when (FIFO count + outstanding) < 2 and redirect_valid=0; imem_req_addr SHALL equal the fetch PC.
REQ-018 On request handshake (valid & ready), the fetch PC SHALL advance by 4, and the request PC SHALL be saved for the response.
REQ-019 imem_req_valid, once asserted, SHALL stay asserted with a stable address until ready, unless a redirect arrives.
REQ-020 FSM states: IDLE (nothing outstanding), WAIT (outstanding, keep response), DROP (outstanding, discard response).
REQ-021 Transitions: IDLE->WAIT on handshake. WAIT->IDLE on rsp_valid, or WAIT->WAIT if a new handshake happens in the same cycle. WAIT->DROP on redirect without rsp_valid. WAIT->IDLE on redirect with rsp_valid, and the response is discarded. DROP->IDLE on rsp_valid. Redirect in DROP SHALL stay in DROP.
REQ-022 In WAIT, a response SHALL push {imem_rsp_data, request PC} into a 2-entry FIFO.
REQ-023 inst_valid SHALL equal FIFO non-empty and redirect_valid=0; inst and inst_pc are the FIFO head.
REQ-024 A pop occurs on inst_valid & inst_ready; push and pop in the same cycle SHALL both take effect with count unchanged.
REQ-025 Credit rule guarantees no push when full; an overflow is an assertion failure.
REQ-026 On redirect_valid, the FIFO SHALL be flushed, the fetch PC SHALL load {redirect_pc[63:2],2'b00}, and no request is issued that cycle. Fetch resumes the next cycle at the earliest.
REQ-027 Latency: request issued in the cycle after reset release; an instruction appears on inst_valid the cycle after its rsp_valid.
REQ-028 FIFO pointers SHALL wrap modulo 2; PC arithmetic SHALL wrap modulo 2^64.

Reset
REQ-029 On rst: state=IDLE, FIFO count=0, pointers=0, fetch PC=RESET_PC, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
REQ-030 Reset mid-operation SHALL abandon any outstanding request. The memory side SHALL treat a response after reset as stale, and a response in the first cycle after reset is ignored.

Structure
REQ-031 INST_BUS, DATA_BUS widths, RESET_PC value and FSM state encodings SHALL live in defines.v.
REQ-032 The 2-entry FIFO SHALL be a sub-module if_fetch_fifo (push/pop/flush, full/empty).

Verification
REQ-033 Reset, ready=1, 1-cycle memory -> addresses 0x80000000, 0x80000004, 0x80000008 in order; inst_pc matches each; inst_ready=1 gives one instruction per 2 cycles.
REQ-034 inst_ready=0 for 10 cycles -> FIFO fills to 2, then imem_req_valid=0; the first ready pops 0x80000000.
REQ-035 Redirect to 0x80001002 while WAIT -> next response dropped; the next request address is 0x80001000; the flushed entries never appear.
REQ-036 Redirect in the same cycle as rsp_valid -> response discarded; state IDLE; fetch from the redirect target next cycle.
REQ-037 imem_req_ready=0 for 5 cycles -> address held at 0x80000000, valid held high; no PC advance.
REQ-038 rst asserted during WAIT with a FIFO of 1 -> next cycle all outputs at reset values; the fetch restarts at 0x80000000.
